hs_ram_arbiter: RTL and testbench
=================================

HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, RAM address width.
REQ-002 Parameter RD_LAT, 1, RAM read latency in cycles (1..4).
REQ-003 Parameter PAUSE_TMO, 1023, max cycles spent waiting for pause acknowledge.
REQ-004 clk_sys  in  1  single system clock (48 MHz); all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_addr  in  ADDR_W  CPU work-RAM address.
REQ-007 cpu_we  in  1  CPU write enable.
REQ-008 cpu_wdata  in  8  CPU write data.
REQ-009 hs_req  in  1  hiscore engine requests the RAM port (level).
REQ-010 hs_stb  in  1  one access strobe, qualified by hs_ready.
REQ-011 hs_we  in  1  strobe is a write when 1, a read when 0.
REQ-012 hs_addr  in  ADDR_W  hiscore address.
REQ-013 hs_wdata  in  8  hiscore write data.
REQ-014 hs_ready  out  1  arbiter accepts hs_stb this cycle.
REQ-015 hs_valid  out  1  one-cycle pulse; hs_rdata is valid.
REQ-016 hs_rdata  out  8  registered read data.
REQ-017 hs_err  out  1  one-cycle pulse on pause timeout or grant abort.
REQ-018 cpu_pause_req  out  1  request to the pause block to halt the CPU.
REQ-019 cpu_paused  in  1  CPU halted acknowledge.
REQ-020 ram_addr / ram_we / ram_wdata  out  ADDR_W/1/8  muxed RAM port.
REQ-021 ram_rdata  in  8  RAM read data.

Function
REQ-022 FSM states: IDLE, PAUSE_WAIT, GRANT, RD_WAIT, RELEASE, REARM.
REQ-023 IDLE: RAM port driven combinationally from cpu_*. hs_req=1 moves to PAUSE_WAIT.
REQ-024 PAUSE_WAIT: cpu_pause_req=1 and the timeout counter increments. cpu_paused=1 moves to GRANT.
REQ-025 PAUSE_WAIT timeout: the counter reaching PAUSE_TMO pulses hs_err and moves to REARM. The check uses the counter value before increment, so exit occurs PAUSE_TMO+1 cycles after entry.
REQ-026 hs_req dropping in PAUSE_WAIT moves to RELEASE with no error.
REQ-027 GRANT and RD_WAIT: the RAM port is driven from hs_*, and the CPU write path is forced off (ram_we follows only hs).
REQ-028 GRANT: hs_ready=1. A write strobe asserts ram_we for the same cycle and the FSM stays in GRANT. A read strobe registers the address and moves to RD_WAIT.
REQ-029 RD_WAIT: hs_ready=0 and the registered address is held. After RD_LAT cycles, ram_rdata is captured into hs_rdata, hs_valid pulses for one cycle, and the FSM returns to GRANT.
REQ-030 Read latency: hs_valid is asserted exactly RD_LAT+1 cycles after the accepted read strobe.
REQ-031 hs_req=0 in GRANT moves to RELEASE. In RD_WAIT, the pending read completes first.
REQ-032 cpu_paused dropping in GRANT or RD_WAIT pulses hs_err, discards any pending read (no hs_valid), and moves to RELEASE.
REQ-033 RELEASE: one cycle with the RAM port on hs_addr and ram_we=0. cpu_pause_req drops on exit; the next state is IDLE.
REQ-034 REARM: cpu_pause_req=0 and the port is on the CPU. The FSM waits for hs_req=0, then moves to IDLE, so a stuck request cannot re-pause the CPU.
REQ-035 hs_stb outside hs_ready=1 is ignored with no side effect.
REQ-036 Simultaneous hs_stb and hs_req falling edge in GRANT: the strobe is ignored and the FSM moves to RELEASE.

Reset
REQ-037 Reset value of every output and state: FSM=IDLE, cpu_pause_req=0, hs_ready=0, hs_valid=0, hs_err=0, hs_rdata=0, counters=0, RAM port on the CPU.
REQ-038 Reset asserted in any state returns to IDLE on the next edge with no hs_valid/hs_err pulse, and cpu_pause_req is released immediately.

Structure
REQ-039 The shared package mario_hs_pkg holds the state enum, the RD_LAT maximum, and the default PAUSE_TMO constant.
REQ-040 One sub-module, hs_rd_delay, implements the RD_LAT-stage valid shift register with a synchronous flush input.

Verification
REQ-041 hs_req=1, cpu_paused rises 3 cycles later, write strobe addr 16'h6100 data 8'hA5 -> ram_we=1 for exactly 1 cycle with ram_addr=6100, ram_wdata=A5; cpu_we during the grant has no effect.
REQ-042 RD_LAT=2, read 16'h6101 with RAM returning 8'h3C -> hs_valid pulses 3 cycles after the strobe with hs_rdata=3C, and hs_ready=0 in between.
REQ-043 PAUSE_TMO=15, cpu_paused held at 0 -> hs_err pulses 16 cycles after PAUSE_WAIT entry, cpu_pause_req drops, and the FSM stays in REARM while hs_req=1.
REQ-044 cpu_paused drops during RD_WAIT -> hs_err pulses, no hs_valid is produced, RELEASE lasts 1 cycle, then IDLE.
REQ-045 Reset asserted mid-GRANT -> all outputs reach reset values next cycle and ram_addr follows cpu_addr.
REQ-046 hs_req drops together with hs_stb in GRANT -> no RAM write occurs, and cpu_pause_req deasserts 1 cycle later.

Source files
------------

// File: rtl/mario_hs_pkg.sv
// Shared types and constants for the hiscore RAM arbiter: FSM state encoding,
// read-latency bounds and the default pause-acknowledge timeout.
package mario_hs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PAUSE_WAIT,
      ST_GRANT,
      ST_RD_WAIT,
      ST_RELEASE,
      ST_REARM
   } hs_state_e;

   localparam int RD_LAT_MAX    = 4;
   localparam int PAUSE_TMO_DEF = 1023;

   // Keeps an out-of-range latency parameter from building a zero-width or oversized pipe.
   function automatic int clamp_lat(input int lat);
      if (lat < 1) return 1;
      if (lat > RD_LAT_MAX) return RD_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/hs_ram_arbiter_if.sv
// Hiscore engine <-> arbiter handshake bus: level request, qualified strobes,
// registered read return and error pulse.
interface hs_ram_arbiter_if #(
   parameter int ADDR_W = 16
) ();
   logic              req;
   logic              stb;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;
   logic              ready;
   logic              valid;
   logic [7:0]        rdata;
   logic              err;

   modport master (output req, stb, we, addr, wdata, input ready, valid, rdata, err);
   modport slave  (input req, stb, we, addr, wdata, output ready, valid, rdata, err);
endinterface

// File: rtl/hs_ram_arbiter_rd_delay.sv
// Read-valid delay line: a launch pulse emerges on done RD_LAT cycles later;
// flush drops anything in flight.
module hs_rd_delay #(
   parameter int RD_LAT = 1
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic flush,
   input  logic launch,
   output logic done
);
   logic [RD_LAT-1:0] stage_reg;
   logic [RD_LAT-1:0] stage_next;

   genvar gi;
   generate
      for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign stage_next[gi] = launch;
         end else begin : g_tail
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk_sys) begin
      if (reset || flush) begin
         stage_reg <= '0;
      end else begin
         stage_reg <= stage_next;
      end
   end

   assign done = stage_reg[RD_LAT-1];
endmodule

// File: rtl/hs_ram_arbiter.sv
// Shares the CPU work-RAM port with the hiscore engine: pauses the CPU, grants
// the port for single-byte accesses, and hands it back on release or fault.
module hs_ram_arbiter
   import mario_hs_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int RD_LAT    = 1,
   parameter int PAUSE_TMO = PAUSE_TMO_DEF
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [7:0]        cpu_wdata,
   hs_ram_arbiter_if.slave   hs,
   output logic              cpu_pause_req,
   input  logic              cpu_paused,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);
   localparam int LAT   = clamp_lat(RD_LAT);
   localparam int CNT_W = (PAUSE_TMO < 1) ? 1 : $clog2(PAUSE_TMO + 1);

   hs_state_e         state_reg, state_next;
   logic [CNT_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [7:0]        rdata_reg, rdata_next;
   logic              valid_reg, valid_next;
   logic              err_reg, err_next;
   logic              rd_launch, rd_flush, rd_done;

   hs_rd_delay #(.RD_LAT(LAT)) u_rd_delay (
      .clk_sys (clk_sys),
      .reset   (reset),
      .flush   (rd_flush),
      .launch  (rd_launch),
      .done    (rd_done)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         tmo_cnt_reg <= '0;
         addr_reg    <= '0;
         rdata_reg   <= '0;
         valid_reg   <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         tmo_cnt_reg <= tmo_cnt_next;
         addr_reg    <= addr_next;
         rdata_reg   <= rdata_next;
         valid_reg   <= valid_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      tmo_cnt_next  = '0;
      addr_next     = addr_reg;
      rdata_next    = rdata_reg;
      valid_next    = 1'b0;
      err_next      = 1'b0;
      rd_launch     = 1'b0;
      rd_flush      = 1'b0;
      hs.ready      = 1'b0;
      cpu_pause_req = 1'b0;
      ram_addr      = cpu_addr;
      ram_we        = cpu_we;
      ram_wdata     = cpu_wdata;

      unique case (state_reg)
         ST_IDLE: begin
            if (hs.req) state_next = ST_PAUSE_WAIT;
         end
         ST_PAUSE_WAIT: begin
            cpu_pause_req = 1'b1;
            if (!hs.req) begin
               state_next = ST_RELEASE;
            end else if (cpu_paused) begin
               state_next = ST_GRANT;
            end else if (tmo_cnt_reg == CNT_W'(PAUSE_TMO)) begin
               err_next   = 1'b1;
               state_next = ST_REARM;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
         end
         ST_GRANT: begin
            cpu_pause_req = 1'b1;
            ram_addr      = hs.addr;
            ram_wdata     = hs.wdata;
            ram_we        = 1'b0;
            // A falling request or lost pause wins over a strobe in the same cycle.
            if (!cpu_paused) begin
               err_next   = 1'b1;
               state_next = ST_RELEASE;
            end else if (!hs.req) begin
               state_next = ST_RELEASE;
            end else begin
               hs.ready = 1'b1;
               if (hs.stb && hs.we) begin
                  ram_we = 1'b1;
               end else if (hs.stb) begin
                  addr_next  = hs.addr;
                  rd_launch  = 1'b1;
                  state_next = ST_RD_WAIT;
               end
            end
         end
         ST_RD_WAIT: begin
            cpu_pause_req = 1'b1;
            ram_addr      = addr_reg;
            ram_wdata     = hs.wdata;
            ram_we        = 1'b0;
            if (!cpu_paused) begin
               err_next   = 1'b1;
               rd_flush   = 1'b1;
               state_next = ST_RELEASE;
            end else if (rd_done) begin
               rdata_next = ram_rdata;
               valid_next = 1'b1;
               state_next = ST_GRANT;
            end
         end
         ST_RELEASE: begin
            cpu_pause_req = 1'b1;
            ram_addr      = hs.addr;
            ram_wdata     = hs.wdata;
            ram_we        = 1'b0;
            state_next    = ST_IDLE;
         end
         ST_REARM: begin
            if (!hs.req) state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Reset hands the CPU its port and pause line back in the same cycle.
      if (reset) begin
         cpu_pause_req = 1'b0;
         hs.ready      = 1'b0;
         rd_launch     = 1'b0;
         ram_addr      = cpu_addr;
         ram_we        = cpu_we;
         ram_wdata     = cpu_wdata;
      end
   end

   assign hs.valid = valid_reg;
   assign hs.rdata = rdata_reg;
   assign hs.err   = err_reg;
endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter: stimulus queues expected RAM writes, read
// returns and error pulses; a negedge monitor pops and compares them.
module tb_hs_ram_arbiter;
   localparam int ADDR_W    = 16;
   localparam int RD_LAT    = 2;
   localparam int PAUSE_TMO = 15;
   localparam int K_WR      = 0;
   localparam int K_VALID   = 1;
   localparam int K_ERR     = 2;

   typedef struct {
      int          kind;
      int          cyc;
      logic [15:0] addr;
      logic [7:0]  data;
   } ev_t;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;
   logic        cpu_pause_req;
   logic        cpu_paused;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  ram_pipe;
   logic [7:0]  mem [0:65535];
   int          cyc    = 0;
   int          n_vec  = 0;
   int          n_miss = 0;
   ev_t         exp_q[$];

   hs_ram_arbiter_if #(.ADDR_W(ADDR_W)) hs_bus ();

   hs_ram_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .PAUSE_TMO(PAUSE_TMO)) dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .cpu_addr      (cpu_addr),
      .cpu_we        (cpu_we),
      .cpu_wdata     (cpu_wdata),
      .hs            (hs_bus),
      .cpu_pause_req (cpu_pause_req),
      .cpu_paused    (cpu_paused),
      .ram_addr      (ram_addr),
      .ram_we        (ram_we),
      .ram_wdata     (ram_wdata),
      .ram_rdata     (ram_rdata)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // Two-register RAM: data for an address presented in cycle T is on ram_rdata in T+2.
   always @(posedge clk_sys) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_pipe  <= mem[ram_addr];
      ram_rdata <= ram_pipe;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int at, input logic [15:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = kind;
      e.cyc  = at;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input logic [15:0] a, input logic [7:0] d);
      ev_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_miss++;
         $display("FAIL stray_event: got kind %0d addr %h data %h at cycle %0d, required none",
                  kind, a, d, cyc);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.addr !== a || e.data !== d) begin
         n_miss++;
         $display("FAIL event: got kind %0d cyc %0d addr %h data %h, required kind %0d cyc %0d addr %h data %h",
                  kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
      end else begin
         $display("ok   event kind %0d addr %h data %h (cycle %0d)", kind, a, d, cyc);
      end
   endtask

   always @(negedge clk_sys) begin
      if (!reset) begin
         if (ram_we)       observe(K_WR, ram_addr, ram_wdata);
         if (hs_bus.valid) observe(K_VALID, 16'h0000, hs_bus.rdata);
         if (hs_bus.err)   observe(K_ERR, 16'h0000, 8'h00);
      end
   end

   task automatic next();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      hs_bus.req   = 1'b0;
      hs_bus.stb   = 1'b0;
      hs_bus.we    = 1'b0;
      hs_bus.addr  = 16'h0000;
      hs_bus.wdata = 8'h00;
      cpu_addr     = 16'h1234;
      cpu_we       = 1'b0;
      cpu_wdata    = 8'h00;
      cpu_paused   = 1'b0;

      // Reset state
      repeat (3) next();
      settle();
      check("rst_pause_req", cpu_pause_req, 0);
      check("rst_ready", hs_bus.ready, 0);
      check("rst_valid", hs_bus.valid, 0);
      check("rst_err", hs_bus.err, 0);
      check("rst_rdata", hs_bus.rdata, 0);
      check("rst_ram_addr", ram_addr, 16'h1234);
      next();
      reset = 1'b0;

      // CPU owns the port in IDLE: preload 6101 with 3C through it
      next();
      cpu_addr = 16'h6101; cpu_wdata = 8'h3C; cpu_we = 1'b1;
      expect_ev(K_WR, cyc, 16'h6101, 8'h3C);
      next();
      cpu_we = 1'b0; cpu_addr = 16'h0040;

      // Pause handshake, then a granted write with a competing CPU write
      next();
      hs_bus.req = 1'b1;
      next();
      settle();
      check("wait_pause_req", cpu_pause_req, 1);
      check("wait_port_cpu", ram_addr, 16'h0040);
      next();
      next();
      cpu_paused = 1'b1;
      next();
      hs_bus.stb = 1'b1; hs_bus.we = 1'b1; hs_bus.addr = 16'h6100; hs_bus.wdata = 8'hA5;
      cpu_we = 1'b1; cpu_addr = 16'h0055; cpu_wdata = 8'hFF;
      expect_ev(K_WR, cyc, 16'h6100, 8'hA5);
      settle();
      check("grant_ready", hs_bus.ready, 1);
      check("grant_ram_addr", ram_addr, 16'h6100);
      next();
      hs_bus.stb = 1'b0; hs_bus.we = 1'b0;
      settle();
      check("cpu_we_blocked", ram_we, 0);
      next();
      cpu_we = 1'b0;

      // Read 6101 with RD_LAT=2: valid 3 cycles after the strobe
      next();
      hs_bus.stb = 1'b1; hs_bus.addr = 16'h6101;
      t = cyc;
      expect_ev(K_VALID, t + 3, 16'h0000, 8'h3C);
      next();
      hs_bus.stb = 1'b0; hs_bus.addr = 16'h0000;
      settle();
      check("rdwait_ready_1", hs_bus.ready, 0);
      check("rdwait_addr_held", ram_addr, 16'h6101);
      next();
      settle();
      check("rdwait_ready_2", hs_bus.ready, 0);
      next();
      settle();
      check("ready_after_read", hs_bus.ready, 1);

      // Back-to-back read of the byte written by the engine
      hs_bus.stb = 1'b1; hs_bus.addr = 16'h6100;
      t = cyc;
      expect_ev(K_VALID, t + 3, 16'h0000, 8'hA5);
      next();
      hs_bus.stb = 1'b0;
      next();
      next();
      settle();
      check("rdata_readback", hs_bus.rdata, 8'hA5);

      // Request drops together with a write strobe: no write, pause held 1 more cycle
      next();
      hs_bus.req = 1'b0; hs_bus.stb = 1'b1; hs_bus.we = 1'b1;
      hs_bus.addr = 16'h6102; hs_bus.wdata = 8'h77;
      settle();
      check("drop_ready", hs_bus.ready, 0);
      check("drop_no_write", ram_we, 0);
      next();
      hs_bus.stb = 1'b0; hs_bus.we = 1'b0;
      settle();
      check("release_pause_req", cpu_pause_req, 1);
      check("release_port_hs", ram_addr, 16'h6102);
      next();
      settle();
      check("idle_pause_req", cpu_pause_req, 0);
      check("idle_port_cpu", ram_addr, 16'h0055);
      cpu_paused = 1'b0;

      // Pause timeout: err 16 cycles after PAUSE_WAIT entry, then REARM while req held
      next();
      hs_bus.req = 1'b1;
      t = cyc;
      expect_ev(K_ERR, t + 17, 16'h0000, 8'h00);
      repeat (16) next();
      settle();
      check("tmo_last_wait", cpu_pause_req, 1);
      next();
      settle();
      check("tmo_pause_drop", cpu_pause_req, 0);
      hs_bus.stb = 1'b1; hs_bus.we = 1'b1; hs_bus.addr = 16'h6103;
      repeat (3) next();
      settle();
      check("rearm_hold", cpu_pause_req, 0);
      check("rearm_port_cpu", ram_addr, 16'h0055);
      hs_bus.stb = 1'b0; hs_bus.we = 1'b0; hs_bus.req = 1'b0;
      next();
      next();

      // Request withdrawn while waiting for pause: RELEASE, no error
      next();
      hs_bus.req = 1'b1;
      next();
      settle();
      check("pw_pause_req", cpu_pause_req, 1);
      hs_bus.req = 1'b0;
      next();
      settle();
      check("pw_release", cpu_pause_req, 1);
      next();
      settle();
      check("pw_idle", cpu_pause_req, 0);

      // Pause lost during RD_WAIT: err, read discarded, one RELEASE cycle
      next();
      hs_bus.req = 1'b1;
      next();
      cpu_paused = 1'b1;
      next();
      hs_bus.stb = 1'b1; hs_bus.we = 1'b0; hs_bus.addr = 16'h6101;
      settle();
      check("abort_ready", hs_bus.ready, 1);
      next();
      hs_bus.stb = 1'b0; cpu_paused = 1'b0;
      t = cyc;
      expect_ev(K_ERR, t + 1, 16'h0000, 8'h00);
      next();
      hs_bus.req = 1'b0;
      settle();
      check("abort_release", cpu_pause_req, 1);
      check("abort_no_we", ram_we, 0);
      next();
      settle();
      check("abort_idle", cpu_pause_req, 0);
      next();
      next();

      // Reset asserted mid-GRANT
      cpu_paused = 1'b1;
      next();
      hs_bus.req = 1'b1;
      next();
      next();
      settle();
      check("pre_rst_ready", hs_bus.ready, 1);
      reset = 1'b1; cpu_addr = 16'hBEEF;
      settle();
      check("rst_pause_immediate", cpu_pause_req, 0);
      next();
      settle();
      check("midrst_ready", hs_bus.ready, 0);
      check("midrst_valid", hs_bus.valid, 0);
      check("midrst_err", hs_bus.err, 0);
      check("midrst_rdata", hs_bus.rdata, 0);
      check("midrst_ram_addr", ram_addr, 16'hBEEF);
      check("midrst_pause_req", cpu_pause_req, 0);
      next();
      reset = 1'b0; hs_bus.req = 1'b0; cpu_paused = 1'b0;
      next();
      settle();
      check("post_rst_pause_req", cpu_pause_req, 0);
      repeat (3) next();

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
